// File: rtl/uart_rx_deserializer_pkg.sv
// Shared UART definitions: configuration enums, receive FSM states and the parity helper
// used by both the receive datapath and line-side stimulus.
package uart_rx_deserializer_pkg;

   localparam int UART_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } UartRxStateE;

   typedef enum logic {
      EVEN_PARITY = 1'b0,
      ODD_PARITY  = 1'b1
   } PARITY_TYPE_E;

   typedef enum logic [4:0] {
      X13 = 5'd13,
      X16 = 5'd16
   } OVER_SMPLING_E;

   typedef enum logic [1:0] {
      ONE_BIT = 2'd1,
      TWO_BIT = 2'd2
   } STOP_BIT_E;

   typedef enum logic [3:0] {
      FIVE_BIT  = 4'd5,
      SIX_BIT   = 4'd6,
      SEVEN_BIT = 4'd7,
      EIGHT_BIT = 4'd8
   } DATA_TYPE_E;

   // Parity bit a transmitter appends; unused upper data bits must be zero.
   function automatic logic expected_parity(input logic [UART_DATA_WIDTH-1:0] data,
                                            input logic                       odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Downstream word handshake of the UART receiver: data, valid/ready and status flags.
interface uart_rx_deserializer_if
   import uart_rx_deserializer_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH
) ();

   logic [DATA_WIDTH-1:0] rxData;
   logic                  rxValid;
   logic                  rxReady;
   logic                  parityError;
   logic                  framingError;
   logic                  overrunError;

   modport master (
      output rxData,
      output rxValid,
      input  rxReady,
      output parityError,
      output framingError,
      output overrunError
   );

   modport slave (
      input  rxData,
      input  rxValid,
      output rxReady,
      input  parityError,
      input  framingError,
      input  overrunError
   );

endinterface

// File: rtl/uart_baud_tick_gen.sv
// Free-running oversample tick generator: counts 0..max(divisor,1)-1 and ticks at terminal
// count; a restart forces the count back to zero so ticks align with a detected start edge.
module uart_baud_tick_gen #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 restart,
   input  logic [DIV_WIDTH-1:0] divisor,
   output logic                 tick
);

   localparam logic [DIV_WIDTH-1:0] CNT_ZERO = {DIV_WIDTH{1'b0}};
   localparam logic [DIV_WIDTH-1:0] CNT_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

   logic [DIV_WIDTH-1:0] term_s;
   logic [DIV_WIDTH-1:0] cnt_nxt_s;
   logic [DIV_WIDTH-1:0] cnt_r;
   logic                 tick_r;

   // Terminal count (divisor 0 behaves as 1) and next counter value.
   always_comb begin
      term_s    = CNT_ZERO;
      cnt_nxt_s = CNT_ZERO;
      if (divisor == CNT_ZERO) begin
         term_s = CNT_ZERO;
      end else begin
         term_s = divisor - CNT_ONE;
      end
      if (restart) begin
         cnt_nxt_s = CNT_ZERO;
      end else if (cnt_r >= term_s) begin
         cnt_nxt_s = CNT_ZERO;
      end else begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end
   end

   // Counter and registered tick, high while the counter sits at terminal count.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r  <= CNT_ZERO;
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_nxt_s;
         tick_r <= (cnt_nxt_s == term_s);
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive stage: synchronizes rx, detects and validates the start bit, samples LSB-first
// data, optional parity and 1-2 stop bits mid-bit, and delivers words over valid/ready.
module uart_rx_deserializer
   import uart_rx_deserializer_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int DIV_WIDTH   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rx,
   input  logic [DIV_WIDTH-1:0]   baudDivisor,
   input  logic [4:0]             overSample,
   input  logic [3:0]             dataType,
   input  logic                   parityEnable,
   input  logic                   parityType,
   input  logic [1:0]             stopBits,
   uart_rx_deserializer_if.master rx_if
);

   localparam int IDX_W = $clog2(DATA_WIDTH);

   logic [SYNC_STAGES-1:0] rx_sync_r;
   logic                   rx_s;
   logic                   tick_s;
   logic                   restart_s;
   logic                   latch_cfg_s;
   logic                   deliver_s;

   UartRxStateE            state_r, state_nxt_s;
   logic [4:0]             sample_cnt_r, sample_cnt_nxt_s;
   logic [3:0]             bit_cnt_r, bit_cnt_nxt_s;
   logic [DATA_WIDTH-1:0]  data_r, data_nxt_s;
   logic                   par_err_r, par_err_nxt_s;
   logic                   frm_err_r, frm_err_nxt_s;

   logic [4:0]             os_in_s, os_r, os_m1_s, half_m1_s;
   logic [3:0]             dbits_in_s, dbits_r;
   logic                   par_en_r, par_odd_r, two_stop_r;

   logic [DATA_WIDTH-1:0]  rx_data_r;
   logic                   rx_valid_r, parity_error_r, framing_error_r, overrun_error_r;

   // Metastability synchronizer; idles high like the line.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_sync_r <= {SYNC_STAGES{1'b1}};
      end else begin
         rx_sync_r <= {rx_sync_r[SYNC_STAGES-2:0], rx};
      end
   end

   assign rx_s = rx_sync_r[SYNC_STAGES-1];

   uart_baud_tick_gen #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_tick_gen (
      .clk     (clk),
      .reset   (reset),
      .restart (restart_s),
      .divisor (baudDivisor),
      .tick    (tick_s)
   );

   // Out-of-range configuration values fall back to X16 / 8 data bits / 1 stop bit.
   always_comb begin
      os_in_s    = 5'd16;
      dbits_in_s = 4'd8;
      if (overSample == 5'd13) begin
         os_in_s = 5'd13;
      end else begin
         os_in_s = 5'd16;
      end
      if ((dataType >= 4'd5) && (dataType <= 4'd8)) begin
         dbits_in_s = dataType;
      end else begin
         dbits_in_s = 4'd8;
      end
   end

   // Frame configuration, captured when a start edge is seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         os_r       <= 5'd16;
         dbits_r    <= 4'd8;
         par_en_r   <= 1'b0;
         par_odd_r  <= 1'b0;
         two_stop_r <= 1'b0;
      end else if (latch_cfg_s) begin
         os_r       <= os_in_s;
         dbits_r    <= dbits_in_s;
         par_en_r   <= parityEnable;
         par_odd_r  <= parityType;
         two_stop_r <= (stopBits == 2'd2);
      end
   end

   assign os_m1_s   = os_r - 5'd1;
   assign half_m1_s = {1'b0, os_r[4:1]} - 5'd1;

   // Receive FSM next state and datapath updates.
   always_comb begin
      state_nxt_s      = state_r;
      sample_cnt_nxt_s = sample_cnt_r;
      bit_cnt_nxt_s    = bit_cnt_r;
      data_nxt_s       = data_r;
      par_err_nxt_s    = par_err_r;
      frm_err_nxt_s    = frm_err_r;
      restart_s        = 1'b0;
      latch_cfg_s      = 1'b0;
      deliver_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (!rx_s) begin
               state_nxt_s      = START;
               sample_cnt_nxt_s = 5'd0;
               bit_cnt_nxt_s    = 4'd0;
               data_nxt_s       = {DATA_WIDTH{1'b0}};
               par_err_nxt_s    = 1'b0;
               frm_err_nxt_s    = 1'b0;
               restart_s        = 1'b1;
               latch_cfg_s      = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: begin
            if (tick_s && (sample_cnt_r == half_m1_s)) begin
               sample_cnt_nxt_s = 5'd0;
               bit_cnt_nxt_s    = 4'd0;
               // A line back high at mid start bit was only a glitch.
               if (rx_s) begin
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = DATA;
               end
            end else if (tick_s) begin
               sample_cnt_nxt_s = sample_cnt_r + 5'd1;
            end else begin
               state_nxt_s = START;
            end
         end
         DATA: begin
            if (tick_s && (sample_cnt_r == os_m1_s)) begin
               data_nxt_s[bit_cnt_r[IDX_W-1:0]] = rx_s;
               sample_cnt_nxt_s                 = 5'd0;
               if (bit_cnt_r == (dbits_r - 4'd1)) begin
                  bit_cnt_nxt_s = 4'd0;
                  state_nxt_s   = par_en_r ? PARITY : STOP;
               end else begin
                  bit_cnt_nxt_s = bit_cnt_r + 4'd1;
               end
            end else if (tick_s) begin
               sample_cnt_nxt_s = sample_cnt_r + 5'd1;
            end else begin
               state_nxt_s = DATA;
            end
         end
         PARITY: begin
            if (tick_s && (sample_cnt_r == os_m1_s)) begin
               sample_cnt_nxt_s = 5'd0;
               bit_cnt_nxt_s    = 4'd0;
               state_nxt_s      = STOP;
               if (rx_s != expected_parity(data_r, par_odd_r)) begin
                  par_err_nxt_s = 1'b1;
               end else begin
                  par_err_nxt_s = par_err_r;
               end
            end else if (tick_s) begin
               sample_cnt_nxt_s = sample_cnt_r + 5'd1;
            end else begin
               state_nxt_s = PARITY;
            end
         end
         STOP: begin
            if (tick_s && (sample_cnt_r == os_m1_s)) begin
               sample_cnt_nxt_s = 5'd0;
               if (!rx_s) begin
                  frm_err_nxt_s = 1'b1;
               end else begin
                  frm_err_nxt_s = frm_err_r;
               end
               // Leave at mid stop bit so a back-to-back start edge is not missed.
               if (bit_cnt_r == (two_stop_r ? 4'd1 : 4'd0)) begin
                  deliver_s     = 1'b1;
                  bit_cnt_nxt_s = 4'd0;
                  state_nxt_s   = IDLE;
               end else begin
                  bit_cnt_nxt_s = bit_cnt_r + 4'd1;
               end
            end else if (tick_s) begin
               sample_cnt_nxt_s = sample_cnt_r + 5'd1;
            end else begin
               state_nxt_s = STOP;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Receive FSM state and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         sample_cnt_r <= 5'd0;
         bit_cnt_r    <= 4'd0;
         data_r       <= {DATA_WIDTH{1'b0}};
         par_err_r    <= 1'b0;
         frm_err_r    <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         sample_cnt_r <= sample_cnt_nxt_s;
         bit_cnt_r    <= bit_cnt_nxt_s;
         data_r       <= data_nxt_s;
         par_err_r    <= par_err_nxt_s;
         frm_err_r    <= frm_err_nxt_s;
      end
   end

   // Output word register: load, hold until accepted, or drop with an overrun pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data_r       <= {DATA_WIDTH{1'b0}};
         rx_valid_r      <= 1'b0;
         parity_error_r  <= 1'b0;
         framing_error_r <= 1'b0;
         overrun_error_r <= 1'b0;
      end else begin
         overrun_error_r <= 1'b0;
         if (deliver_s) begin
            if (!rx_valid_r || rx_if.rxReady) begin
               rx_data_r       <= data_r;
               parity_error_r  <= par_err_r;
               framing_error_r <= frm_err_nxt_s;
               rx_valid_r      <= 1'b1;
            end else begin
               overrun_error_r <= 1'b1;
            end
         end else if (rx_valid_r && rx_if.rxReady) begin
            rx_valid_r <= 1'b0;
         end
      end
   end

   assign rx_if.rxData       = rx_data_r;
   assign rx_if.rxValid      = rx_valid_r;
   assign rx_if.parityError  = parity_error_r;
   assign rx_if.framingError = framing_error_r;
   assign rx_if.overrunError = overrun_error_r;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: drives hand-built serial frames and compares the
// delivered words, flags, handshake behaviour and latency against hand-computed values.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;
   import uart_rx_deserializer_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx = 1'b1;
   logic [15:0] baudDivisor = 16'd1;
   logic [4:0]  overSample = X16;
   logic [3:0]  dataType = EIGHT_BIT;
   logic        parityEnable = 1'b1;
   logic        parityType = EVEN_PARITY;
   logic [1:0]  stopBits = ONE_BIT;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          k0 = 0;
   int          rise_cyc = 0;
   int          n_acc = 0;
   int          n_ovr = 0;
   int          acc0 = 0;
   int          ovr0 = 0;
   logic [7:0]  cap_data = 8'h00;
   logic        cap_perr = 1'b0;
   logic        cap_ferr = 1'b0;
   logic        valid_q = 1'b0;

   uart_rx_deserializer_if #(.DATA_WIDTH(8)) rx_if ();

   uart_rx_deserializer #(
      .DATA_WIDTH  (8),
      .DIV_WIDTH   (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .baudDivisor  (baudDivisor),
      .overSample   (overSample),
      .dataType     (dataType),
      .parityEnable (parityEnable),
      .parityType   (parityType),
      .stopBits     (stopBits),
      .rx_if        (rx_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Consumer-side monitor: records accepted words, valid rise time and overrun pulses.
   always @(negedge clk) begin
      if (rx_if.rxValid && !valid_q) rise_cyc <= cyc;
      valid_q <= rx_if.rxValid;
      if (rx_if.rxValid && rx_if.rxReady) begin
         cap_data <= rx_if.rxData;
         cap_perr <= rx_if.parityError;
         cap_ferr <= rx_if.framingError;
         n_acc    <= n_acc + 1;
      end
      if (rx_if.overrunError) n_ovr <= n_ovr + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One frame; the final stop bit lasts last_len cycles, every other bit bit_len cycles.
   task automatic send_frame(input logic [7:0] data, input int nbits, input int bit_len,
                             input logic par_en, input logic par_bit, input int nstop,
                             input logic stop2, input int last_len);
      @(posedge clk);
      #1; rx = 1'b0; k0 = cyc;
      repeat (bit_len) @(posedge clk);
      for (int i = 0; i < nbits; i++) begin
         #1; rx = data[i];
         repeat (bit_len) @(posedge clk);
      end
      if (par_en) begin
         #1; rx = par_bit;
         repeat (bit_len) @(posedge clk);
      end
      #1; rx = 1'b1;
      if (nstop == 2) begin
         repeat (bit_len) @(posedge clk);
         #1; rx = stop2;
      end
      repeat (last_len) @(posedge clk);
      #1; rx = 1'b1;
   endtask

   initial begin
      rx_if.rxReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_valid", {31'd0, rx_if.rxValid}, 32'd0);
      check_eq("reset_data", {24'd0, rx_if.rxData}, 32'd0);
      check_eq("reset_perr", {31'd0, rx_if.parityError}, 32'd0);
      check_eq("reset_ferr", {31'd0, rx_if.framingError}, 32'd0);
      check_eq("reset_ovr", {31'd0, rx_if.overrunError}, 32'd0);
      reset = 1'b0;
      repeat (10) @(posedge clk);

      // 0xA5, even parity bit 0; latency = 2 sync + 1 detect + 8 half-bit + 10 bits * 16.
      acc0 = n_acc;
      send_frame(8'hA5, 8, 16, 1'b1, 1'b0, 1, 1'b1, 16);
      repeat (4) @(posedge clk); #1;
      check_eq("a5_count", n_acc, acc0 + 1);
      check_eq("a5_data", {24'd0, cap_data}, 32'h0000_00A5);
      check_eq("a5_perr", {31'd0, cap_perr}, 32'd0);
      check_eq("a5_ferr", {31'd0, cap_ferr}, 32'd0);
      check_eq("a5_latency", rise_cyc - k0, 32'd171);

      acc0 = n_acc;
      send_frame(8'h3C, 8, 16, 1'b1, 1'b1, 1, 1'b1, 16);
      repeat (4) @(posedge clk); #1;
      check_eq("3c_count", n_acc, acc0 + 1);
      check_eq("3c_data", {24'd0, cap_data}, 32'h0000_003C);
      check_eq("3c_perr", {31'd0, cap_perr}, 32'd1);
      check_eq("3c_ferr", {31'd0, cap_ferr}, 32'd0);

      // Low second stop bit is shortened so the line is high again before a start check.
      baudDivisor = 16'd3; overSample = X13; dataType = FIVE_BIT;
      parityEnable = 1'b0; stopBits = TWO_BIT;
      acc0 = n_acc;
      send_frame(8'h15, 5, 39, 1'b0, 1'b0, 2, 1'b0, 26);
      repeat (60) @(posedge clk); #1;
      check_eq("15_count", n_acc, acc0 + 1);
      check_eq("15_data", {24'd0, cap_data}, 32'h0000_0015);
      check_eq("15_ferr", {31'd0, cap_ferr}, 32'd1);
      check_eq("15_perr", {31'd0, cap_perr}, 32'd0);

      baudDivisor = 16'd1; overSample = X16; dataType = EIGHT_BIT;
      parityEnable = 1'b1; parityType = EVEN_PARITY; stopBits = ONE_BIT;
      acc0 = n_acc;
      @(posedge clk); #1; rx = 1'b0;
      repeat (4) @(posedge clk); #1; rx = 1'b1;
      repeat (40) @(posedge clk); #1;
      check_eq("glitch_count", n_acc, acc0);
      check_eq("glitch_valid", {31'd0, rx_if.rxValid}, 32'd0);
      send_frame(8'h81, 8, 16, 1'b1, 1'b0, 1, 1'b1, 16);
      repeat (4) @(posedge clk); #1;
      check_eq("81_count", n_acc, acc0 + 1);
      check_eq("81_data", {24'd0, cap_data}, 32'h0000_0081);
      check_eq("81_perr", {31'd0, cap_perr}, 32'd0);

      rx_if.rxReady = 1'b0;
      acc0 = n_acc; ovr0 = n_ovr;
      send_frame(8'h11, 8, 16, 1'b1, 1'b0, 1, 1'b1, 16);
      #1;
      check_eq("11_valid", {31'd0, rx_if.rxValid}, 32'd1);
      check_eq("11_data", {24'd0, rx_if.rxData}, 32'h0000_0011);
      send_frame(8'h22, 8, 16, 1'b1, 1'b0, 1, 1'b1, 16);
      #1;
      check_eq("22_ovr_count", n_ovr, ovr0 + 1);
      check_eq("22_data_kept", {24'd0, rx_if.rxData}, 32'h0000_0011);
      check_eq("22_valid", {31'd0, rx_if.rxValid}, 32'd1);
      // Ready is high only for the delivery cycle of 0x33 (edge k0+171).
      fork
         send_frame(8'h33, 8, 16, 1'b1, 1'b0, 1, 1'b1, 16);
         begin
            @(posedge clk); #1;
            repeat (170) @(posedge clk);
            #1; rx_if.rxReady = 1'b1;
            @(posedge clk);
            #1; rx_if.rxReady = 1'b0;
         end
      join
      #1;
      check_eq("33_data", {24'd0, rx_if.rxData}, 32'h0000_0033);
      check_eq("33_valid", {31'd0, rx_if.rxValid}, 32'd1);
      check_eq("33_ovr_count", n_ovr, ovr0 + 1);
      check_eq("33_old_accepted", {24'd0, cap_data}, 32'h0000_0011);
      check_eq("33_acc_count", n_acc, acc0 + 1);
      rx_if.rxReady = 1'b1;
      repeat (3) @(posedge clk); #1;
      check_eq("33_drained", {24'd0, cap_data}, 32'h0000_0033);
      check_eq("33_drain_count", n_acc, acc0 + 2);
      check_eq("33_valid_low", {31'd0, rx_if.rxValid}, 32'd0);

      // 0xFF interrupted by reset halfway through data bit 3; line then stays idle.
      acc0 = n_acc;
      @(posedge clk); #1; rx = 1'b0;
      repeat (16) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         #1; rx = 1'b1;
         repeat (16) @(posedge clk);
      end
      #1; rx = 1'b1;
      repeat (8) @(posedge clk);
      #1; reset = 1'b1;
      repeat (2) @(posedge clk);
      #1; reset = 1'b0;
      check_eq("mid_rst_valid", {31'd0, rx_if.rxValid}, 32'd0);
      check_eq("mid_rst_data", {24'd0, rx_if.rxData}, 32'd0);
      check_eq("mid_rst_perr", {31'd0, rx_if.parityError}, 32'd0);
      check_eq("mid_rst_ferr", {31'd0, rx_if.framingError}, 32'd0);
      check_eq("mid_rst_ovr", {31'd0, rx_if.overrunError}, 32'd0);
      repeat (60) @(posedge clk); #1;
      check_eq("mid_rst_count", n_acc, acc0);
      send_frame(8'h5A, 8, 16, 1'b1, 1'b0, 1, 1'b1, 16);
      repeat (4) @(posedge clk); #1;
      check_eq("5a_count", n_acc, acc0 + 1);
      check_eq("5a_data", {24'd0, cap_data}, 32'h0000_005A);
      check_eq("5a_perr", {31'd0, cap_perr}, 32'd0);
      check_eq("5a_ferr", {31'd0, cap_ferr}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
